// File: rtl/flow_led_key_ctrl_pkg.sv
// flow_led_pkg: shared debounce state encoding, timing and key index constants
package flow_led_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;
  localparam int DEBOUNCE_20MS = 1_000_000;
  localparam int KEY_STOP = 0;
  localparam int KEY_MOD = 1;
endpackage

// File: rtl/flow_led_key_ctrl_if.sv
// flow_led_key_ctrl_if: raw key pins in, clean stop/direction controls out
interface flow_led_key_ctrl_if;
  logic       key_stop_n;
  logic       key_mod_n;
  logic       flow_led_stop;
  logic       mod;
  logic [1:0] key_pulse;
  logic [1:0] key_level;
  modport master (output key_stop_n, key_mod_n, input flow_led_stop, mod, key_pulse, key_level);
  modport slave (input key_stop_n, key_mod_n, output flow_led_stop, mod, key_pulse, key_level);
endinterface

// File: rtl/flow_led_key_ctrl_key_debounce.sv
// key_debounce: two-flop synchroniser, debounce FSM and counter for one active-low key
module key_debounce
  import flow_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_20MS,
  parameter int CNT_W = 20
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic key_n_i,
  output logic pulse_o,
  output logic level_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);
  logic [1:0]       sync_q;
  logic             s;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  assign s = sync_q[1];
  // Synchroniser, state, counter and pulse registers; rst_n is released synchronously upstream
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end
  // Next state: any level change restarts the stability count; only an accepted press pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: if (!s) begin
        state_d = PRESS_WAIT;
        cnt_d   = '0;
      end
      PRESS_WAIT: if (s) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q == LAST) begin
        state_d = PRESSED;
        pulse_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      PRESSED: if (s) begin
        state_d = RELEASE_WAIT;
        cnt_d   = '0;
      end
      RELEASE_WAIT: if (!s) begin
        state_d = PRESSED;
        cnt_d   = '0;
      end else if (cnt_q == LAST) state_d = IDLE;
      else cnt_d = cnt_q + 1'b1;
    endcase
  end
  assign pulse_o = pulse_q;
  assign level_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
endmodule

// File: rtl/flow_led_key_ctrl.sv
// flow_led_key_ctrl: debounced stop/direction toggles for the flow-LED counter stage
module flow_led_key_ctrl
  import flow_led_pkg::*;
#(
  parameter int   DEBOUNCE_CYC = DEBOUNCE_20MS,
  parameter int   CNT_W = 20,
  parameter logic MOD_RST = 1'b1
) (
  input logic clk_50m,
  input logic rst_n,
  flow_led_key_ctrl_if.slave bus
);
  logic [1:0] key_n, pulse, level;
  logic       stop_q, stop_d, mod_q, mod_d;
  assign key_n[KEY_STOP] = bus.key_stop_n;
  assign key_n[KEY_MOD]  = bus.key_mod_n;
  for (genvar i = 0; i < 2; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_deb (
      .clk_50m(clk_50m),
      .rst_n  (rst_n),
      .key_n_i(key_n[i]),
      .pulse_o(pulse[i]),
      .level_o(level[i])
    );
  end
  // Each accepted press flips its control one edge after the strobe
  always_comb begin
    stop_d = stop_q ^ pulse[KEY_STOP];
    mod_d  = mod_q ^ pulse[KEY_MOD];
  end
  // Registered controls so the counter never sees a path from the pins
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      stop_q <= 1'b0;
      mod_q  <= MOD_RST;
    end else begin
      stop_q <= stop_d;
      mod_q  <= mod_d;
    end
  end
  assign bus.flow_led_stop = stop_q;
  assign bus.mod           = mod_q;
  assign bus.key_pulse     = pulse;
  assign bus.key_level     = level;
endmodule

// File: tb/tb_flow_led_key_ctrl.sv
// tb_flow_led_key_ctrl: table-driven and directed checks of key debounce and toggles
module tb_flow_led_key_ctrl;
  logic clk_50m = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  flow_led_key_ctrl_if bus();
  flow_led_key_ctrl #(.DEBOUNCE_CYC(8), .CNT_W(4), .MOD_RST(1'b1)) dut (
    .clk_50m(clk_50m),
    .rst_n  (rst_n),
    .bus    (bus)
  );
  always #10 clk_50m = ~clk_50m;
  typedef struct {
    string      name;
    logic       stop_n;
    logic       mod_n;
    int         hold;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [5:0] obs();
    return {bus.flow_led_stop, bus.mod, bus.key_pulse, bus.key_level};
  endfunction
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      #1;
    end
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic add(input string name, input logic sn, input logic mn, input int hold, input logic [5:0] exp);
    vec_t v;
    v.name = name;
    v.stop_n = sn;
    v.mod_n = mn;
    v.hold = hold;
    v.exp = exp;
    tbl.push_back(v);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.key_stop_n = 1'b1;
    bus.key_mod_n = 1'b1;
    step(3);
    chk("reset_vals", int'(obs()), int'(6'b01_00_00));
    rst_n = 1'b1;
  endtask
  initial begin
    int npulse;
    int got;
    bus.key_stop_n = 1'b1;
    bus.key_mod_n = 1'b1;
    step(3);
    chk("reset_hold", int'(obs()), int'(6'b01_00_00));
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk($sformatf("post_reset_%0d", i), int'(obs()), int'(6'b01_00_00));
    end
    // {stop, mod, pulse[1:0], level[1:0]} after holding the keys for the given cycles
    add("stop_wait",     1'b0, 1'b1, 10, 6'b01_00_00);
    add("stop_pulse",    1'b0, 1'b1, 1,  6'b01_01_01);
    add("stop_tog",      1'b0, 1'b1, 1,  6'b11_00_01);
    add("stop_hold",     1'b0, 1'b1, 18, 6'b11_00_01);
    add("stop_rel_wait", 1'b1, 1'b1, 10, 6'b11_00_01);
    add("stop_rel",      1'b1, 1'b1, 1,  6'b11_00_00);
    add("idle",          1'b1, 1'b1, 5,  6'b11_00_00);
    add("stop2_pulse",   1'b0, 1'b1, 11, 6'b11_01_01);
    add("stop2_tog",     1'b0, 1'b1, 1,  6'b01_00_01);
    add("stop2_rel",     1'b1, 1'b1, 20, 6'b01_00_00);
    add("both_pulse",    1'b0, 1'b0, 11, 6'b01_11_11);
    add("both_tog",      1'b0, 1'b0, 1,  6'b10_00_11);
    add("both_hold",     1'b0, 1'b0, 8,  6'b10_00_11);
    add("both_rel",      1'b1, 1'b1, 20, 6'b10_00_00);
    foreach (tbl[i]) begin
      bus.key_stop_n = tbl[i].stop_n;
      bus.key_mod_n = tbl[i].mod_n;
      step(tbl[i].hold);
      chk(tbl[i].name, int'(obs()), int'(tbl[i].exp));
    end
    do_reset();
    for (int i = 0; i < 40; i++) begin
      bus.key_mod_n = ((i / 3) % 2) == 1;
      step(1);
      chk($sformatf("bounce_%0d", i), int'({bus.mod, bus.key_pulse[1], bus.key_level[1]}), int'(3'b100));
    end
    bus.key_mod_n = 1'b1;
    step(20);
    chk("bounce_end", int'({bus.mod, bus.key_pulse[1], bus.key_level[1]}), int'(3'b100));
    npulse = 0;
    bus.key_mod_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      npulse += int'(bus.key_pulse[1]);
    end
    for (int g = 0; g < 4; g++) begin
      bus.key_mod_n = (g % 2) == 0;
      for (int i = 0; i < 3; i++) begin
        step(1);
        npulse += int'(bus.key_pulse[1]);
      end
    end
    bus.key_mod_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1);
      npulse += int'(bus.key_pulse[1]);
    end
    chk("relb_level_held", int'(bus.key_level[1]), 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      npulse += int'(bus.key_pulse[1]);
    end
    chk("relb_level_fell", int'(bus.key_level[1]), 0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      npulse += int'(bus.key_pulse[1]);
    end
    chk("relb_pulses", npulse, 1);
    chk("relb_mod", int'(bus.mod), 0);
    do_reset();
    bus.key_stop_n = 1'b0;
    step(5);
    rst_n = 1'b0;
    #1;
    chk("mr_assert", int'(obs()), int'(6'b01_00_00));
    step(3);
    chk("mr_during", int'(obs()), int'(6'b01_00_00));
    rst_n = 1'b1;
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (bus.key_pulse[0]) begin
        got = i;
        break;
      end
    end
    chk($sformatf("mr_latency_%0d", got), int'(got >= 10 && got <= 12), 1);
    step(1);
    chk("mr_stop", int'(bus.flow_led_stop), 1);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      npulse += int'(bus.key_pulse[0]);
    end
    chk("mr_no_repeat", npulse, 0);
    chk("mr_final", int'(obs()), int'(6'b11_00_01));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
